// File: rtl/a_shift_register_pkg.sv
// Shared width and operation encoding for the A working register.
package a_shift_register_pkg;

    localparam int unsigned REG_W = 9;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        LOAD   = 2'd1,
        RSHIFT = 2'd2,
        LSHIFT = 2'd3
    } op_sel_t;

endpackage

// File: rtl/a_shift_reg_cell.sv
// One bit of the A register: async-reset flop fed by a 4:1 next-state mux.
module a_shift_reg_cell
    import a_shift_register_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  op_sel_t op,
    input  logic    load_bit,
    input  logic    right_nb,
    input  logic    left_nb,
    output logic    q
);

    logic d;

    always_comb begin
        d = q;
        case (op)
            HOLD:    d = q;
            LOAD:    d = load_bit;
            RSHIFT:  d = right_nb;
            LSHIFT:  d = left_nb;
            default: d = q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/a_shift_register.sv
// 9-bit A register for the ALU datapath: load, logical/arithmetic right
// shift, left shift with serial entry, or hold; true and inverted outputs.
module a_shift_register
    import a_shift_register_pkg::*;
#(
    parameter int unsigned W = REG_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         rshift,
    input  logic         lshift,
    input  logic         a7_mem,
    input  logic         left_shift_entry_wire,
    input  logic [W-1:0] a,
    output logic [W-1:0] q,
    output logic [W-1:0] not_q
);

    op_sel_t      op;
    logic [W-1:0] right_in;
    logic [W-1:0] left_in;

    always_comb begin
        op = HOLD;
        if (lshift) begin
            op = LSHIFT;
        end else if (rshift) begin
            op = RSHIFT;
        end else if (load) begin
            op = LOAD;
        end
    end

    // Bit 7 either keeps its value (arithmetic) or takes the extension bit.
    always_comb begin
        left_in  = {q[W-2:0], left_shift_entry_wire};
        right_in = {1'b0, (a7_mem ? q[W-2] : q[W-1]), q[W-2:1]};
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        a_shift_reg_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .op       (op),
            .load_bit (a[i]),
            .right_nb (right_in[i]),
            .left_nb  (left_in[i]),
            .q        (q[i])
        );
    end

    assign not_q = ~q;

endmodule

// File: tb/tb_a_shift_register.sv
// Self-checking bench for a_shift_register using an expected-value queue.
module tb_a_shift_register;

    logic       clk;
    logic       rst;
    logic       load;
    logic       rshift;
    logic       lshift;
    logic       a7_mem;
    logic       left_shift_entry_wire;
    logic [8:0] a;
    logic [8:0] q;
    logic [8:0] not_q;

    int unsigned errors;
    int unsigned checks;
    logic [8:0]  sb[$];
    logic [8:0]  model;

    a_shift_register #(.W(9)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .load                  (load),
        .rshift                (rshift),
        .lshift                (lshift),
        .a7_mem                (a7_mem),
        .left_shift_entry_wire (left_shift_entry_wire),
        .a                     (a),
        .q                     (q),
        .not_q                 (not_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Independent reference: the register is treated as an integer value.
    function automatic logic [8:0] ref_next(input logic [8:0] cur, input logic l, input logic r,
                                            input logic s, input logic a7, input logic e,
                                            input logic [8:0] d);
        logic [8:0] n;
        n = cur;
        if (s) begin
            n = 9'((cur * 2) | {8'd0, e});
        end else if (r) begin
            n = cur / 2;
            n[8] = 1'b0;
            n[7] = a7 ? cur[7] : cur[8];
        end else if (l) begin
            n = d;
        end
        return n;
    endfunction

    task automatic pop_check(input string tag);
        logic [8:0] exp;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s: scoreboard empty got %h expected entry", tag, q);
        end else begin
            exp = sb.pop_front();
            check(tag, q, exp);
            check({tag, "_n"}, not_q, ~exp);
        end
    endtask

    task automatic step(input string tag, input logic l, input logic r, input logic s,
                        input logic a7, input logic e, input logic [8:0] d,
                        input logic [8:0] exp);
        @(negedge clk);
        load = l;
        rshift = r;
        lshift = s;
        a7_mem = a7;
        left_shift_entry_wire = e;
        a = d;
        sb.push_back(exp);
        model = exp;
        @(posedge clk);
        #1;
        pop_check(tag);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        load = 1'b0;
        rshift = 1'b0;
        lshift = 1'b0;
        a7_mem = 1'b0;
        left_shift_entry_wire = 1'b0;
        a = '0;
        #1;
        sb.push_back(9'h000);
        pop_check("reset_init");
        @(negedge clk);
        rst = 1'b0;

        step("load_017",   1, 0, 0, 0, 0, 9'h017, 9'h017);
        step("load_06a",   1, 0, 0, 0, 0, 9'h06A, 9'h06A);
        for (int i = 0; i < 3; i++)
            step("hold",   0, 0, 0, 1, 1, 9'h1FF, 9'h06A);
        check("hold_notq", not_q, 9'h195);
        step("rsh_log",    0, 1, 0, 0, 1, 9'h1FF, 9'h035);
        step("lsh_e0_a",   0, 0, 1, 1, 0, 9'h1FF, 9'h06A);
        step("lsh_e0_b",   0, 0, 1, 1, 0, 9'h1FF, 9'h0D4);
        step("lsh_e1",     0, 0, 1, 0, 1, 9'h000, 9'h1A9);
        step("load_0d4",   1, 0, 0, 0, 0, 9'h0D4, 9'h0D4);
        step("rsh_ar_a",   0, 1, 0, 1, 1, 9'h000, 9'h0EA);
        step("rsh_ar_b",   0, 1, 0, 1, 1, 9'h000, 9'h0F5);
        step("load_1d5",   1, 0, 0, 0, 0, 9'h1D5, 9'h1D5);
        step("b8_migrate", 0, 1, 0, 0, 0, 9'h000, 9'h0EA);
        step("b8_arith",   0, 1, 0, 1, 0, 9'h000, 9'h0F5);
        step("load_035",   1, 0, 0, 0, 0, 9'h035, 9'h035);
        step("prio_all",   1, 1, 1, 1, 0, 9'h1FF, 9'h06A);
        step("prio_rl",    1, 1, 0, 0, 1, 9'h1FF, 9'h035);

        // Asynchronous reset asserted mid-cycle with a load pending.
        step("load_0d4b",  1, 0, 0, 0, 0, 9'h0D4, 9'h0D4);
        #2;
        rst = 1'b1;
        load = 1'b1;
        a = 9'h1FF;
        #1;
        sb.push_back(9'h000);
        pop_check("rst_async");
        @(posedge clk);
        #1;
        sb.push_back(9'h000);
        pop_check("rst_held");
        @(negedge clk);
        rst = 1'b0;
        load = 1'b0;
        model = 9'h000;

        for (int i = 0; i < 40; i++) begin
            logic       l, r, s, a7, e;
            logic [8:0] d;
            l  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 3) == 0);
            a7 = 1'($urandom_range(0, 1));
            e  = 1'($urandom_range(0, 1));
            d  = 9'($urandom_range(0, 511));
            step("random", l, r, s, a7, e, d, ref_next(model, l, r, s, a7, e, d));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
